shift_rotate_unit: RTL and testbench
====================================

SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand/result width in bits (legal: power of two, 8..64).
REQ-002 Parameter CNTW, default 5, SHALL set the shift-count width and SHALL equal log2(WIDTH).
REQ-003 Port Clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port Clear  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port start  input  1  SHALL request an operation.
REQ-006 Port op  input  3  SHALL select the mode: 000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR; 101-111 illegal.
REQ-007 Port operand  input  WIDTH  SHALL carry the value to shift.
REQ-008 Port count  input  CNTW  SHALL carry the shift amount, 0..WIDTH-1.
REQ-009 Port busy  output  1  SHALL be high while an operation is executing.
REQ-010 Port done  output  1  SHALL be a one-cycle completion strobe.
REQ-011 Port result  output  WIDTH  SHALL carry the shifted value.
REQ-012 Port cout  output  1  SHALL carry the last bit shifted or rotated out.
REQ-013 Port err  output  1  SHALL flag an illegal op code for the completed operation.

Function
REQ-014 The unit SHALL implement states IDLE, RUN and DONE, and SHALL shift exactly one bit position per clock in RUN.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL latch operand, op and count; the next state SHALL be RUN if count>=1, else DONE.
REQ-016 start SHALL be ignored while in RUN; latched operands SHALL NOT change.
REQ-017 In RUN, each edge SHALL shift the working register by one position and decrement the remaining count; the edge that consumes the last position SHALL move to DONE.
REQ-018 Latency: done SHALL be high in the cycle after edge start+n+1 for count n>=1, and in the cycle after edge start+1 for n=0.
REQ-019 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); DONE SHALL last exactly one cycle, then return to IDLE unless start is accepted.
REQ-020 SHL SHALL fill LSB with 0; SHR SHALL fill MSB with 0; SHRA SHALL replicate the original MSB; ROL SHALL feed the MSB to the LSB; ROR SHALL feed the LSB to the MSB.
REQ-021 cout SHALL equal the bit leaving the register on the final step (the MSB for SHL/ROL, the LSB for SHR/SHRA/ROR); for count 0 it SHALL be 0.
REQ-022 count 0 SHALL yield result = operand for every legal op.
REQ-023 An illegal op SHALL go directly to DONE regardless of count, with result = operand, cout=0 and err=1; a legal op SHALL give err=0.
REQ-024 result, cout and err SHALL remain stable from DONE until the next accepted start; their values in RUN are don't-care.

Reset
REQ-025 Clear low SHALL immediately force state IDLE, busy=0, done=0, result=0, cout=0, err=0, and clear the remaining count.
REQ-026 Clear asserted during RUN SHALL abort the operation with no done strobe; start SHALL be honoured only at the first rising edge after Clear deasserts.

Verification (WIDTH=32)
REQ-027 ROL, operand 0x00000022, count 8 -> busy for 8 cycles; then done=1, result 0x00002200, cout=0, err=0.
REQ-028 ROR 0x00000001 by 1 -> result 0x80000000, cout=1; SHRA 0x80000000 by 4 -> 0xF8000000, cout=0; SHR 0x80000000 by 4 -> 0x08000000.
REQ-029 SHL 0xDEADBEEF count 0 -> done one edge after start, result 0xDEADBEEF, cout=0; SHL 0x80000001 by 31 -> 0x80000000, cout=0.
REQ-030 start pulsed with new operands at cycle 3 of an 8-cycle ROL -> ignored; the original result 0x00002200 is still produced; a start coincident with done is accepted back-to-back.
REQ-031 Clear driven low mid-RUN between clock edges -> busy, done, result and cout go to 0 immediately, and no done strobe follows.
REQ-032 op 110, operand 0x12345678, count 5 -> done after one edge, result 0x12345678, err=1, cout=0.

Source files
------------

// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit
//   Sequential shifter/rotator. It moves the operand by one bit position per
//   clock, so an operation of count n keeps the unit busy for n cycles.
//
//   Ports
//     Clock    : rising-edge clock
//     Clear    : asynchronous active-low reset
//     start    : request; accepted in IDLE or DONE, ignored in RUN
//     op       : 000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR (others illegal)
//     operand  : value to shift (WIDTH bits)
//     count    : shift amount, 0..WIDTH-1 (CNTW = log2(WIDTH) bits)
//     busy     : high while in RUN
//     done     : one-cycle completion strobe (state DONE)
//     result   : shifted value, held from DONE until the next accepted start
//     cout     : last bit shifted/rotated out (0 for count 0 or illegal op)
//     err      : illegal op code for the completed operation
module shift_rotate_unit #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 5
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand,
   input  logic [CNTW-1:0]  count,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             err
);

   localparam logic [2:0] OP_SHL  = 3'b000;
   localparam logic [2:0] OP_SHR  = 3'b001;
   localparam logic [2:0] OP_SHRA = 3'b010;
   localparam logic [2:0] OP_ROL  = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Everything that describes an operation in flight.
   typedef struct packed {
      logic [2:0]       op;
      logic [CNTW-1:0]  rem;
      logic [WIDTH-1:0] work;
      logic             cout;
      logic             err;
   } ctx_t;

   state_t state, state_nxt;
   ctx_t   ctx, ctx_nxt;

   logic             illegal;
   logic [WIDTH-1:0] step_val;
   logic             step_out;

   assign illegal = (op > OP_ROR);

   // One-position step of the working register for the latched op.
   // SHRA re-inserts the current MSB; since every step preserves it, this
   // is always the original operand's sign bit.
   always_comb begin
      step_val = ctx.work;
      step_out = 1'b0;
      case (ctx.op)
         OP_SHL: begin
            step_val = {ctx.work[WIDTH-2:0], 1'b0};
            step_out = ctx.work[WIDTH-1];
         end
         OP_SHR: begin
            step_val = {1'b0, ctx.work[WIDTH-1:1]};
            step_out = ctx.work[0];
         end
         OP_SHRA: begin
            step_val = {ctx.work[WIDTH-1], ctx.work[WIDTH-1:1]};
            step_out = ctx.work[0];
         end
         OP_ROL: begin
            step_val = {ctx.work[WIDTH-2:0], ctx.work[WIDTH-1]};
            step_out = ctx.work[WIDTH-1];
         end
         OP_ROR: begin
            step_val = {ctx.work[0], ctx.work[WIDTH-1:1]};
            step_out = ctx.work[0];
         end
         default: begin
            // Illegal ops never enter RUN; hold the register.
            step_val = ctx.work;
            step_out = 1'b0;
         end
      endcase
   end

   // Next-state and context update.
   always_comb begin
      state_nxt = state;
      ctx_nxt   = ctx;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               ctx_nxt.op   = op;
               ctx_nxt.rem  = count;
               ctx_nxt.work = operand;
               ctx_nxt.cout = 1'b0;
               ctx_nxt.err  = illegal;
               // Illegal op or zero count completes on the accepting edge
               // with result = operand and cout = 0.
               if (illegal || (count == '0)) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = RUN;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            ctx_nxt.work = step_val;
            ctx_nxt.cout = step_out;
            ctx_nxt.rem  = ctx.rem - CNTW'(1);
            if (ctx.rem == CNTW'(1)) begin
               state_nxt = DONE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state <= IDLE;
         ctx   <= '0;
      end else begin
         state <= state_nxt;
         ctx   <= ctx_nxt;
      end
   end

   assign busy   = (state == RUN);
   assign done   = (state == DONE);
   assign result = ctx.work;
   assign cout   = ctx.cout;
   assign err    = ctx.err;

endmodule

// File: tb/tb_shift_rotate_unit.sv
module tb_shift_rotate_unit;
   localparam int W = 32;

   logic          Clock = 1'b0;
   logic          Clear = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    op = '0;
   logic [W-1:0]  operand = '0;
   logic [4:0]    count = '0;
   logic          busy, done, cout, err;
   logic [W-1:0]  result;

   int total = 0;
   int bad = 0;

   shift_rotate_unit #(.WIDTH(W), .CNTW(5)) dut (
      .Clock(Clock), .Clear(Clear), .start(start), .op(op),
      .operand(operand), .count(count), .busy(busy), .done(done),
      .result(result), .cout(cout), .err(err)
   );

   always #5 Clock = ~Clock;

   // Reference: {err, cout, result} from the arithmetic definition of each op.
   function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] a, input int n);
      logic [W-1:0] r;
      logic c;
      if (o > 3'd4) return {1'b1, 1'b0, a};
      if (n == 0) return {2'b00, a};
      case (o)
         3'd0: begin r = a << n; c = a[W-n]; end
         3'd1: begin r = a >> n; c = a[n-1]; end
         3'd2: begin r = W'($signed(a) >>> n); c = a[n-1]; end
         3'd3: begin r = (a << n) | (a >> (W-n)); c = a[W-n]; end
         default: begin r = (a >> n) | (a << (W-n)); c = a[n-1]; end
      endcase
      return {1'b0, c, r};
   endfunction

   function automatic int exp_lat(input logic [2:0] o, input int n);
      return (o > 3'd4 || n == 0) ? 1 : n + 1;
   endfunction

   // Called at a negedge; drives start for one cycle, returns at next negedge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input int n);
      start = 1'b1; op = o; operand = a; count = 5'(n);
      @(negedge Clock);
      start = 1'b0;
   endtask

   // Waits (bounded) for done; cyc = negedges since the accepting edge,
   // bc = number of those sampled with busy high.
   task automatic wait_done(output int cyc, output int bc);
      cyc = 1; bc = busy ? 1 : 0;
      while (!done && cyc < 200) begin
         @(negedge Clock);
         cyc++;
         if (busy && !done) bc++;
      end
   endtask

   task automatic test_reset();
      #1 Clear = 1'b0;
      #1;
      total++;
      if ({busy, done, cout, err, result} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", {busy, done, cout, err, result});
      end
      @(negedge Clock);
      Clear = 1'b1;
      @(negedge Clock);
   endtask

   task automatic test_directed();
      logic [2:0]   ops [7]  = '{3'd3, 3'd4, 3'd2, 3'd1, 3'd0, 3'd0, 3'd6};
      logic [W-1:0] opa [7]  = '{32'h22, 32'h1, 32'h80000000, 32'h80000000, 32'hDEADBEEF, 32'h80000001, 32'h12345678};
      int           cnt [7]  = '{8, 1, 4, 4, 0, 31, 5};
      logic [W+1:0] want [7] = '{{2'b00, 32'h00002200}, {2'b01, 32'h80000000}, {2'b00, 32'hF8000000},
                                 {2'b00, 32'h08000000}, {2'b00, 32'hDEADBEEF}, {2'b00, 32'h80000000},
                                 {2'b10, 32'h12345678}};
      int cyc, bc, el;
      for (int i = 0; i < 7; i++) begin
         issue(ops[i], opa[i], cnt[i]);
         wait_done(cyc, bc);
         el = (ops[i] > 3'd4 || cnt[i] == 0) ? 1 : cnt[i] + 1;
         total++;
         if ({err, cout, result} !== want[i]) begin
            bad++;
            $display("FAIL directed_%0d got=%h want=%h", i, {err, cout, result}, want[i]);
         end
         total++;
         if (cyc !== el || bc !== el - 1) begin
            bad++;
            $display("FAIL directed_lat_%0d got=%0d/%0d want=%0d/%0d", i, cyc, bc, el, el - 1);
         end
         @(negedge Clock);
         total++;
         if (done !== 1'b0 || {err, cout, result} !== want[i]) begin
            bad++;
            $display("FAIL directed_hold_%0d done=%b got=%h want=%h", i, done, {err, cout, result}, want[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] o; logic [W-1:0] a; int n, cyc, bc;
      logic [W+1:0] w;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7)); a = $urandom; n = $urandom_range(0, W-1);
         w = model(o, a, n);
         issue(o, a, n);
         wait_done(cyc, bc);
         total++;
         if ({err, cout, result} !== w || cyc !== exp_lat(o, n)) begin
            bad++;
            $display("FAIL random_%0d op=%0d a=%h n=%0d got=%h lat=%0d want=%h lat=%0d",
                     i, o, a, n, {err, cout, result}, cyc, w, exp_lat(o, n));
         end
         if (($urandom & 1) != 0) @(negedge Clock);
      end
   endtask

   task automatic test_ignore_start();
      int cyc, bc;
      issue(3'd3, 32'h22, 8);
      @(negedge Clock);
      start = 1'b1; op = 3'd0; operand = 32'hFFFF0000; count = 5'd3;
      @(negedge Clock);
      start = 1'b0;
      wait_done(cyc, bc);
      total++;
      if ({err, cout, result} !== {2'b00, 32'h00002200} || cyc !== 7) begin
         bad++;
         $display("FAIL ignore_start got=%h rem_lat=%0d want=%h rem_lat=7", {err, cout, result}, cyc, {2'b00, 32'h00002200});
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bc;
      issue(3'd0, 32'h0000000F, 3);
      wait_done(cyc, bc);
      // start coincident with done
      issue(3'd4, 32'h0000000F, 2);
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL b2b_accept busy=%b done=%b want busy=1 done=0", busy, done);
      end
      wait_done(cyc, bc);
      total++;
      if ({err, cout, result} !== model(3'd4, 32'h0000000F, 2) || cyc !== 3) begin
         bad++;
         $display("FAIL b2b_result got=%h lat=%0d want=%h lat=3", {err, cout, result}, cyc, model(3'd4, 32'h0000000F, 2));
      end
   endtask

   task automatic test_clear_midrun();
      int seen = 0;
      int cyc, bc;
      issue(3'd3, 32'hFFFFFFFF, 10);
      @(negedge Clock); @(negedge Clock);
      #2 Clear = 1'b0;
      #1;
      total++;
      if ({busy, done, cout, err, result} !== '0) begin
         bad++;
         $display("FAIL clear_midrun got=%h want=0", {busy, done, cout, err, result});
      end
      @(negedge Clock);
      Clear = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge Clock);
         if (done || busy) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL clear_no_done got=%0d want=0", seen);
      end
      issue(3'd1, 32'h80000000, 4);
      wait_done(cyc, bc);
      total++;
      if ({err, cout, result} !== {2'b00, 32'h08000000} || cyc !== 5) begin
         bad++;
         $display("FAIL after_clear got=%h lat=%0d want=%h lat=5", {err, cout, result}, cyc, {2'b00, 32'h08000000});
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_clear_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
